// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage divide unit: funct3 codes, FSM states
// and common constants.
package ex_div_pkg;

  // RV32M funct3 codes handled by the divider
  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  // Divider FSM states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_END  = 2'b10
  } div_state_e;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage : ex_div_pkg

// File: rtl/ex_div.sv
// EX-stage RV32M divide unit. Runs a WIDTH-step restoring division on the
// operand magnitudes, then sign-corrects and returns quotient or remainder.
// Divide-by-zero and signed overflow skip the iteration and finish in one
// cycle. busy_o holds the earlier pipeline stages while a divide runs.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [4:0]       reg_waddr_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ready_o,
  output logic             busy_o,
  output logic [4:0]       reg_waddr_o
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO_W   = WIDTH'(ZeroWord);

  // Two's-complement negation
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] value);
    negate = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  div_state_e       state_r;
  div_state_e       state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic             is_signed_r;
  logic             is_rem_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] divisor_r;
  logic [4:0]       waddr_r;
  logic             ready_r;

  logic             op_signed_s;
  logic             op_rem_s;
  logic             s1_s;
  logic             s2_s;
  logic [WIDTH-1:0] dividend_abs_s;
  logic [WIDTH-1:0] divisor_abs_s;
  logic             div_zero_s;
  logic             overflow_s;
  logic             special_s;
  logic [WIDTH-1:0] special_res_s;
  logic             accept_s;

  logic [WIDTH:0]   part_rem_s;
  logic [WIDTH:0]   diff_s;
  logic             q_bit_s;
  logic [WIDTH-1:0] rem_nxt_s;
  logic [WIDTH-1:0] quot_nxt_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;
  logic [WIDTH-1:0] final_s;
  logic             last_s;

  // Decode funct3 into signedness and quotient/remainder selection
  always_comb begin
    op_signed_s = 1'b0;
    op_rem_s    = 1'b0;
    case (op_i)
      INST_DIV: begin
        op_signed_s = 1'b1;
        op_rem_s    = 1'b0;
      end
      INST_DIVU: begin
        op_signed_s = 1'b0;
        op_rem_s    = 1'b0;
      end
      INST_REM: begin
        op_signed_s = 1'b1;
        op_rem_s    = 1'b1;
      end
      INST_REMU: begin
        op_signed_s = 1'b0;
        op_rem_s    = 1'b1;
      end
      default: begin
        op_signed_s = 1'b0;
        op_rem_s    = 1'b0;
      end
    endcase
  end

  // Operand magnitudes and detection of the cases that bypass iteration
  always_comb begin
    s1_s           = op_signed_s & dividend_i[WIDTH-1];
    s2_s           = op_signed_s & divisor_i[WIDTH-1];
    dividend_abs_s = s1_s ? negate(dividend_i) : dividend_i;
    divisor_abs_s  = s2_s ? negate(divisor_i) : divisor_i;
    div_zero_s     = (divisor_i == ZERO_W);
    overflow_s     = op_signed_s && (dividend_i == MIN_NEG) && (divisor_i == ALL_ONES);
    special_s      = div_zero_s | overflow_s;
    if (div_zero_s) begin
      special_res_s = op_rem_s ? dividend_i : ALL_ONES;
    end else if (overflow_s) begin
      special_res_s = op_rem_s ? ZERO_W : MIN_NEG;
    end else begin
      special_res_s = ZERO_W;
    end
    accept_s = (state_r == DIV_IDLE) && start_i && !flush_i;
  end

  // One restoring step: the shifted partial remainder is WIDTH+1 bits, so the
  // borrow out of the trial subtraction is the unsigned compare result
  always_comb begin
    part_rem_s = {rem_r, quot_r[WIDTH-1]};
    diff_s     = part_rem_s - {1'b0, divisor_r};
    q_bit_s    = ~diff_s[WIDTH];
    if (q_bit_s) begin
      rem_nxt_s = diff_s[WIDTH-1:0];
    end else begin
      rem_nxt_s = part_rem_s[WIDTH-1:0];
    end
    quot_nxt_s = {quot_r[WIDTH-2:0], q_bit_s};
    q_fix_s    = (is_signed_r && q_neg_r) ? negate(quot_nxt_s) : quot_nxt_s;
    r_fix_s    = (is_signed_r && r_neg_r) ? negate(rem_nxt_s) : rem_nxt_s;
    final_s    = is_rem_r ? r_fix_s : q_fix_s;
    last_s     = (count_r == CNT_LAST);
  end

  // Next-state logic; flush returns to IDLE from any state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      DIV_IDLE: begin
        if (accept_s) begin
          state_nxt_s = special_s ? DIV_END : DIV_CALC;
        end else begin
          state_nxt_s = DIV_IDLE;
        end
      end
      DIV_CALC: begin
        if (flush_i) begin
          state_nxt_s = DIV_IDLE;
        end else if (last_s) begin
          state_nxt_s = DIV_END;
        end else begin
          state_nxt_s = DIV_CALC;
        end
      end
      DIV_END: begin
        state_nxt_s = DIV_IDLE;
      end
      default: begin
        state_nxt_s = DIV_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DIV_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture on accept and iteration registers during CALC
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r     <= {CNT_W{1'b0}};
      is_signed_r <= 1'b0;
      is_rem_r    <= 1'b0;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      rem_r       <= {WIDTH{1'b0}};
      quot_r      <= {WIDTH{1'b0}};
      divisor_r   <= {WIDTH{1'b0}};
      waddr_r     <= 5'd0;
    end else if (accept_s) begin
      count_r     <= {CNT_W{1'b0}};
      is_signed_r <= op_signed_s;
      is_rem_r    <= op_rem_s;
      q_neg_r     <= s1_s ^ s2_s;
      r_neg_r     <= s1_s;
      rem_r       <= {WIDTH{1'b0}};
      quot_r      <= dividend_abs_s;
      divisor_r   <= divisor_abs_s;
      waddr_r     <= reg_waddr_i;
    end else if ((state_r == DIV_CALC) && !flush_i) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      rem_r   <= rem_nxt_s;
      quot_r  <= quot_nxt_s;
    end else begin
      count_r <= count_r;
    end
  end

  // Result, destination and completion pulse, all loaded on entry to END
  always_ff @(posedge clk) begin
    if (rst) begin
      result_o    <= {WIDTH{1'b0}};
      reg_waddr_o <= 5'd0;
      ready_r     <= 1'b0;
    end else if (accept_s && special_s) begin
      result_o    <= special_res_s;
      reg_waddr_o <= reg_waddr_i;
      ready_r     <= 1'b1;
    end else if ((state_r == DIV_CALC) && !flush_i && last_s) begin
      result_o    <= final_s;
      reg_waddr_o <= waddr_r;
      ready_r     <= 1'b1;
    end else begin
      ready_r <= 1'b0;
    end
  end

  // A flush arriving while in END suppresses the completion pulse
  assign ready_o = ready_r & ~flush_i;
  assign busy_o  = (state_r != DIV_IDLE);

endmodule : ex_div

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed latency/sign/special-case tests,
// flush and reset aborts, busy behaviour and a random sweep against a model.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic [4:0]  reg_waddr_o;

  always #5 clk = ~clk;

  ex_div #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .reg_waddr_i (reg_waddr_i),
    .flush_i     (flush_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .reg_waddr_o (reg_waddr_o)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wa;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   ready_cnt = 0;

  // Count every completion pulse so aborted operations can be checked
  always @(negedge clk) begin
    if (ready_o) ready_cnt++;
  end

  // Reference result using native signed/unsigned arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else if (ovf) return 32'h8000_0000;
        else return 32'(sa / sb);
      end
      3'b101: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else return a / b;
      end
      3'b110: begin
        if (b == 32'd0) return a;
        else if (ovf) return 32'd0;
        else return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        else return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Drive a start request in the next cycle and optionally push its expectation
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic push, input logic [31:0] exp_res,
                       input int exp_lat);
    exp_t e;
    @(posedge clk); #1;
    op_i        = op;
    dividend_i  = a;
    divisor_i   = b;
    reg_waddr_i = wa;
    start_i     = 1'b1;
    if (push) begin
      e.res = exp_res;
      e.wa  = wa;
      e.lat = exp_lat;
      sb_q.push_back(e);
    end
  endtask

  // Wait (bounded) for ready_o; optionally keep start_i high with junk operands
  task automatic await_ready(input int budget, input int hold, output int lat,
                             output logic busy_gap, output logic [31:0] res,
                             output logic [4:0] wa);
    lat      = -1;
    busy_gap = 1'b0;
    res      = 32'd0;
    wa       = 5'd0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (c > hold) begin
        start_i = 1'b0;
      end else begin
        op_i        = 3'b101;
        dividend_i  = $urandom;
        divisor_i   = $urandom_range(1, 1000);
        reg_waddr_i = 5'd31;
      end
      @(negedge clk);
      if (!busy_o) busy_gap = 1'b1;
      if (ready_o) begin
        lat = c;
        res = result_o;
        wa  = reg_waddr_o;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 3'b000;
    dividend_i = 32'd0; divisor_i = 32'd0; reg_waddr_i = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (result_o !== 32'd0) $display("FAIL reset_result: got %h want 0", result_o); else pass_cnt++;
    total_cnt++; if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else pass_cnt++;
    total_cnt++; if (reg_waddr_o !== 5'd0) $display("FAIL reset_waddr: got %0d want 0", reg_waddr_o); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_divu_basic();
    int lat; logic gap; logic [31:0] res; logic [4:0] wa; exp_t e;
    issue(3'b101, 32'd100, 32'd7, 5'd11, 1'b1, 32'd14, 33);
    @(negedge clk);
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL divu_busy_start: got %b want 0", busy_o); else pass_cnt++;
    await_ready(60, 0, lat, gap, res, wa);
    e = sb_q.pop_front();
    total_cnt++; if (lat !== e.lat) $display("FAIL divu_latency: got %0d want %0d", lat, e.lat); else pass_cnt++;
    total_cnt++; if (res !== e.res) $display("FAIL divu_result: got %h want %h", res, e.res); else pass_cnt++;
    total_cnt++; if (wa !== e.wa) $display("FAIL divu_waddr: got %0d want %0d", wa, e.wa); else pass_cnt++;
    total_cnt++; if (gap !== 1'b0) $display("FAIL divu_busy_span: got gap %b want 0", gap); else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++; if (ready_o !== 1'b0) $display("FAIL divu_ready_pulse: got %b want 0", ready_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL divu_busy_after: got %b want 0", busy_o); else pass_cnt++;
    total_cnt++; if (result_o !== 32'd14) $display("FAIL divu_hold: got %h want %h", result_o, 32'd14); else pass_cnt++;
    total_cnt++; if (reg_waddr_o !== 5'd11) $display("FAIL divu_waddr_hold: got %0d want 11", reg_waddr_o); else pass_cnt++;
  endtask

  // Signed and special cases issued back-to-back in the first IDLE cycle
  task automatic test_back_to_back();
    logic [2:0]  t_op  [13];
    logic [31:0] t_a   [13];
    logic [31:0] t_b   [13];
    logic [31:0] t_res [13];
    int          t_lat [13];
    int lat; logic gap; logic [31:0] res; logic [4:0] wa; exp_t e;
    t_op = '{3'b100, 3'b110, 3'b111, 3'b101, 3'b100, 3'b110, 3'b101, 3'b111,
             3'b100, 3'b110, 3'b101, 3'b100, 3'b110};
    t_a  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'd5, 32'd7,
             32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'd7};
    t_b  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0,
             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    t_res = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd7,
              32'h8000_0000, 32'd0, 32'd0, 32'hFFFF_FFFD, 32'd1};
    t_lat = '{33, 33, 33, 33, 1, 1, 1, 1, 1, 1, 33, 33, 33};
    for (int i = 0; i < 13; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 5'(i + 1), 1'b1, t_res[i], t_lat[i]);
      await_ready(60, 0, lat, gap, res, wa);
      e = sb_q.pop_front();
      total_cnt++; if (lat !== e.lat) $display("FAIL b2b%0d_latency: got %0d want %0d", i, lat, e.lat); else pass_cnt++;
      total_cnt++; if (res !== e.res) $display("FAIL b2b%0d_result: got %h want %h", i, res, e.res); else pass_cnt++;
      total_cnt++; if (wa !== e.wa) $display("FAIL b2b%0d_waddr: got %0d want %0d", i, wa, e.wa); else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    int lat; logic gap; logic [31:0] res; logic [4:0] wa; exp_t e;
    int rc0; logic [31:0] prev; logic bgap;
    @(negedge clk);
    prev = result_o;
    rc0  = ready_cnt;
    bgap = 1'b0;
    issue(3'b101, 32'd1000, 32'd3, 5'd7, 1'b0, 32'd0, 0);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (c == 10) flush_i = 1'b1;
      @(negedge clk);
      if (!busy_o || ready_o) bgap = 1'b1;
    end
    total_cnt++; if (bgap !== 1'b0) $display("FAIL flush_busy_span: got gap %b want 0", bgap); else pass_cnt++;
    issue(3'b101, 32'd9, 32'd3, 5'd9, 1'b1, 32'd3, 33);
    flush_i = 1'b0;
    @(negedge clk);
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL flush_busy_drop: got %b want 0", busy_o); else pass_cnt++;
    total_cnt++; if (result_o !== prev) $display("FAIL flush_result_kept: got %h want %h", result_o, prev); else pass_cnt++;
    total_cnt++; if (ready_cnt !== rc0) $display("FAIL flush_no_ready: got %0d want %0d", ready_cnt, rc0); else pass_cnt++;
    await_ready(60, 0, lat, gap, res, wa);
    e = sb_q.pop_front();
    total_cnt++; if (lat !== e.lat) $display("FAIL flush_restart_latency: got %0d want %0d", lat, e.lat); else pass_cnt++;
    total_cnt++; if (res !== e.res) $display("FAIL flush_restart_result: got %h want %h", res, e.res); else pass_cnt++;
    // Flush together with start in IDLE: nothing starts
    issue(3'b101, 32'd50, 32'd5, 5'd2, 1'b0, 32'd0, 0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL flush_start_idle: got busy %b want 0", busy_o); else pass_cnt++;
    // Flush while in END: no completion pulse
    rc0 = ready_cnt;
    issue(3'b100, 32'd5, 32'd0, 5'd4, 1'b0, 32'd0, 0);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    total_cnt++; if (ready_o !== 1'b0) $display("FAIL flush_end_ready: got %b want 0", ready_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b1) $display("FAIL flush_end_busy: got %b want 1", busy_o); else pass_cnt++;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL flush_end_idle: got %b want 0", busy_o); else pass_cnt++;
    total_cnt++; if (ready_cnt !== rc0) $display("FAIL flush_end_no_ready: got %0d want %0d", ready_cnt, rc0); else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    int lat; logic gap; logic [31:0] res; logic [4:0] wa; exp_t e;
    issue(3'b101, 32'd100, 32'd7, 5'd3, 1'b1, 32'd14, 33);
    await_ready(60, 20, lat, gap, res, wa);
    e = sb_q.pop_front();
    total_cnt++; if (lat !== e.lat) $display("FAIL ignore_latency: got %0d want %0d", lat, e.lat); else pass_cnt++;
    total_cnt++; if (res !== e.res) $display("FAIL ignore_result: got %h want %h", res, e.res); else pass_cnt++;
    total_cnt++; if (wa !== e.wa) $display("FAIL ignore_waddr: got %0d want %0d", wa, e.wa); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int rc0;
    issue(3'b101, 32'd1000, 32'd3, 5'd21, 1'b0, 32'd0, 0);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (c == 5) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    rc0 = ready_cnt;
    total_cnt++; if (result_o !== 32'd0) $display("FAIL rstmid_result: got %h want 0", result_o); else pass_cnt++;
    total_cnt++; if (reg_waddr_o !== 5'd0) $display("FAIL rstmid_waddr: got %0d want 0", reg_waddr_o); else pass_cnt++;
    total_cnt++; if (ready_o !== 1'b0) $display("FAIL rstmid_ready: got %b want 0", ready_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy_o); else pass_cnt++;
    repeat (40) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (ready_cnt !== rc0) $display("FAIL rstmid_no_ready: got %0d want %0d", ready_cnt, rc0); else pass_cnt++;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int lat; logic gap; logic [31:0] res; logic [4:0] wa; exp_t e;
    logic [2:0] op; logic [31:0] a; logic [31:0] b; int prints;
    prints = 0;
    for (int n = 0; n < 1200; n++) begin
      op = {1'b1, 2'($urandom_range(0, 3))};
      a  = pick_operand();
      b  = pick_operand();
      issue(op, a, b, 5'($urandom), 1'b1, ref_res(op, a, b), ref_lat(op, a, b));
      await_ready(60, 0, lat, gap, res, wa);
      e = sb_q.pop_front();
      total_cnt++;
      if (lat !== e.lat || wa !== e.wa) begin
        if (prints < 20) $display("FAIL rand%0d_timing: op %b a %h b %h lat %0d want %0d waddr %0d want %0d",
                                  n, op, a, b, lat, e.lat, wa, e.wa);
        prints++;
      end else pass_cnt++;
      total_cnt++;
      if (res !== e.res) begin
        if (prints < 20) $display("FAIL rand%0d_result: op %b a %h b %h got %h want %h", n, op, a, b, res, e.res);
        prints++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_back_to_back();
    test_flush();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_ex_div
